// File: rtl/program_loader_pkg.sv
// Shared definitions for the program-memory loader: default widths and state encodings.
package program_loader_pkg;

  localparam int unsigned DefAddrW = 12;
  localparam int unsigned DefDataW = 8;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHdrHi   = 3'd1;
  localparam logic [2:0] StHdrLo   = 3'd2;
  localparam logic [2:0] StData    = 3'd3;
  localparam logic [2:0] StChk     = 3'd4;
  localparam logic [2:0] StRelease = 3'd5;

  // States in which a host byte can be consumed.
  function automatic logic accepts_host(input logic [2:0] st);
    return (st == StHdrHi) || (st == StHdrLo) || (st == StData) || (st == StChk);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// 4-bit load/down-counter; expire_o pulses while enabled and the count has reached zero.
module hold_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       expire_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i && (count_q == 4'd0);

endmodule

// File: rtl/program_loader.sv
// Host-to-program-memory loader: header (length), data bytes, optional checksum byte, then a
// timed cpu_hold release. Define LOADER_CHECKSUM_EN to enable the trailing checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              load_err
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-9:0] len_hi_q, len_hi_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              hold_expire;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] chk_total;
  assign chk_total = sum_q + host_data;
`endif

  assign host_ready = accepts_host(state_q);
  assign xfer       = host_valid && host_ready;

  hold_timer u_hold_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (state_q != StRelease),
    .load_val_i (4'(HOLD_CYCLES - 1)),
    .en_i       (state_q == StRelease),
    .expire_o   (hold_expire)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    if (state_q == StIdle) begin
      if (load_start) begin
        state_d = StHdrHi;
        err_d   = 1'b0;
      end
    end else if (load_abort) begin
      // Abort takes priority over any byte offered in the same cycle.
      state_d = StIdle;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        StHdrHi: begin
          if (xfer) begin
            len_hi_d = host_data[ADDR_W-9:0];
            state_d  = StHdrLo;
          end
        end
        StHdrLo: begin
          if (xfer) begin
            cnt_d   = {len_hi_q, host_data};
            addr_d  = '0;
            state_d = StData;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end
        StData: begin
          if (xfer) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = host_data;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = chk_total;
`endif
            // cnt_q holds bytes remaining minus one; addr stays put on the final byte.
            if (cnt_q == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = StChk;
`else
              state_d = StRelease;
`endif
            end else begin
              cnt_d  = cnt_q - 1'b1;
              addr_d = addr_q + 1'b1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: begin
          if (xfer) begin
            if (chk_total != '0) begin
              err_d = 1'b1;
            end
            state_d = StRelease;
          end
        end
`endif
        StRelease: begin
          if (hold_expire) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign busy     = (state_q != StIdle);
  assign cpu_hold = busy;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; writes are logged from the memory port and checked
// against hand-computed addresses and data.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start, load_abort, host_valid;
  logic [7:0]  host_data;
  logic        host_ready, mem_we, cpu_hold, busy, done, load_err;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;

  int total = 0;
  int bad   = 0;

  int          wr_count = 0;
  logic [11:0] wl_addr [0:8191];
  logic [7:0]  wl_data [0:8191];

  always #5 clock = ~clock;

  program_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .load_abort (load_abort),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .load_err   (load_err)
  );

  always @(posedge clock) begin
    if (mem_we) begin
      wl_addr[wr_count] <= mem_addr;
      wl_data[wr_count] <= mem_data;
      wr_count          <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int ok = 0;
    host_valid = 1'b1;
    host_data  = b;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (host_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      check("ready_timeout", 32'(ok), 32'd1);
      host_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    host_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int seen = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [11:0] a,
                          input logic [7:0] d);
    check({tag, "_addr"}, 32'(wl_addr[idx]), 32'(a));
    check({tag, "_data"}, 32'(wl_data[idx]), 32'(d));
  endtask

  initial begin
    int          base;
    logic [5:0]  hold_seq, done_seq;
    logic [7:0]  sum, b;
    int          seen;

    reset = 1'b0; load_start = 1'b0; load_abort = 1'b0;
    host_valid = 1'b0; host_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_ready", 32'(host_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Reset in the middle of DATA after three bytes.
    base = wr_count;
    pulse_start();
    check("t1_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00); send_byte(8'h09);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_hold0", 32'(cpu_hold), 32'd0);
    check("t1_we", 32'(mem_we), 32'd0);
    #3 reset = 1'b1;
    @(posedge clock); #1;
    check("t1_count", 32'(wr_count - base), 32'd3);
    check_wr("t1_w0", base, 12'h000, 8'h11);
    check_wr("t1_w2", base + 2, 12'h002, 8'h33);

    // Basic three-byte load with exact release timing.
    base = wr_count;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hEA);
`endif
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      hold_seq[c] = cpu_hold;
      done_seq[c] = done;
    end
    check("t2_hold_seq", 32'(hold_seq), 32'b001111);
    check("t2_done_seq", 32'(done_seq), 32'b010000);
    check("t2_err", 32'(load_err), 32'd0);
    check("t2_count", 32'(wr_count - base), 32'd3);
    check_wr("t2_w0", base, 12'h000, 8'hA1);
    check_wr("t2_w1", base + 1, 12'h001, 8'hB2);
    check_wr("t2_w2", base + 2, 12'h002, 8'hC3);
    @(posedge clock); #1;

    // Same load with gaps between bytes.
    base = wr_count;
    pulse_start();
    foreach (hold_seq[i]) begin end
    begin
      logic [7:0] seq [0:4];
      seq[0] = 8'h00; seq[1] = 8'h02; seq[2] = 8'hA1; seq[3] = 8'hB2; seq[4] = 8'hC3;
      for (int i = 0; i < 5; i++) begin
        send_byte(seq[i]);
        host_data = 8'hEE;
        @(posedge clock); #1;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hEA);
`endif
    wait_done("t3_done");
    check("t3_count", 32'(wr_count - base), 32'd3);
    check_wr("t3_w0", base, 12'h000, 8'hA1);
    check_wr("t3_w1", base + 1, 12'h001, 8'hB2);
    check_wr("t3_w2", base + 2, 12'h002, 8'hC3);

    // Full 4096-byte load.
    base = wr_count;
    sum  = 8'h00;
    pulse_start();
    send_byte(8'hFF); send_byte(8'hFF);
    for (int i = 0; i < 4096; i++) begin
      b = 8'(i * 7 + 3);
      sum = sum + b;
      send_byte(b);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'(0 - sum));
`endif
    wait_done("t4_done");
    check("t4_count", 32'(wr_count - base), 32'd4096);
    check("t4_last_addr", 32'(wl_addr[wr_count - 1]), 32'h0FFF);
    check_wr("t4_first", base, 12'h000, 8'h03);
    check_wr("t4_mid", base + 255, 12'h0FF, 8'(255 * 7 + 3));
    check_wr("t4_last", base + 4095, 12'hFFF, 8'(4095 * 7 + 3));
    check("t4_err", 32'(load_err), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);

    // Abort during DATA; abort wins over a byte offered the same cycle.
    base = wr_count;
    pulse_start();
    send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h55); send_byte(8'h66);
    host_valid = 1'b1; host_data = 8'h77; load_abort = 1'b1;
    @(posedge clock); #1;
    host_valid = 1'b0; load_abort = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_err", 32'(load_err), 32'd1);
    check("t5_we", 32'(mem_we), 32'd0);
    check("t5_hold", 32'(cpu_hold), 32'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    check("t5_no_done", 32'(seen), 32'd0);
    check("t5_count", 32'(wr_count - base), 32'd2);
    @(posedge clock); #1;
    pulse_start();
    check("t5_err_clr", 32'(load_err), 32'd0);
    check("t5_busy2", 32'(busy), 32'd1);
    load_abort = 1'b1;
    @(posedge clock); #1;
    check("t5_err_again", 32'(load_err), 32'd1);
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0; load_abort = 1'b0;
    check("t5_both_busy", 32'(busy), 32'd1);
    check("t5_both_err", 32'(load_err), 32'd0);
    load_abort = 1'b1;
    @(posedge clock); #1;
    load_abort = 1'b0;
    check("t5_idle", 32'(busy), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good then bad.
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'hD0);
    wait_done("t6_done_ok");
    check("t6_err_ok", 32'(load_err), 32'd0);
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'hD1);
    wait_done("t6_done_bad");
    check("t6_err_bad", 32'(load_err), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
